// File: rtl/sr_lock_arbiter.sv
// ---------------------------------------------------------------------------
// sr_lock_arbiter
//
// Round-robin arbiter that shares one external SR flip-flop, used as a "lock"
// flag, among N requesters. A requester that wins arbitration owns the lock.
// The arbiter pulses the flop's set input on the first cycle of ownership. It
// pulses the reset input for the single cycle in which ownership ends. It also
// compares the flop's q output with the lock state that it expects.
//
// Ownership ends in one of three ways:
//   - the owner pulses its rel bit;
//   - the owner drops its req bit;
//   - the watchdog expires.
//
// State sequence: IDLE -> GRANT -> RELEASE (one cycle) -> IDLE. RELEASE always
// returns to IDLE, so there is at least one idle cycle between two grants.
//
// Parameters
//   N        number of requesters (2..16)
//   CW       watchdog counter width
//   TIMEOUT  maximum number of GRANT cycles per ownership; 0 disables the
//            watchdog; must be < 2**CW
//
// Ports
//   clk          rising-edge clock
//   clear        synchronous, active-high reset
//   req[N]       request level per requester, held while ownership is wanted
//   rel[N]       release pulse per requester; only the owner's bit counts
//   sr_q         q output of the shared SR flop
//   gnt[N]       one-hot grant; all zero when there is no owner
//   owner        index of the current owner; 0 when idle
//   busy         high in GRANT and in RELEASE
//   sr_s         set pulse to the shared flop
//   sr_r         reset pulse to the shared flop
//   timeout_err  one-cycle pulse when the watchdog revokes ownership
//   fault        sticky flag: sr_q disagreed with the expected lock state
//
// Every output comes straight from a register.
// ---------------------------------------------------------------------------
module sr_lock_arbiter #(
    parameter int N       = 4,
    parameter int CW      = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         rel,
    input  logic                 sr_q,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 sr_s,
    output logic                 sr_r,
    output logic                 timeout_err,
    output logic                 fault
);

    localparam int OW = $clog2(N);

    // Value of the timer in the last GRANT cycle the owner may hold. When the
    // watchdog is disabled, the timer never moves and this value is unused.
    localparam logic [CW-1:0] TLAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            busy_q, busy_d;
    logic            sr_s_q, sr_s_d;
    logic            sr_r_q, sr_r_d;
    logic            tout_q, tout_d;
    logic            fault_q, fault_d;
    logic [OW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   timer_q, timer_d;

    // -----------------------------------------------------------------------
    // Round-robin pick.
    // Rotate the request vector so that bit 0 is the requester at ptr. Find
    // the lowest set bit of the rotated vector. Add ptr back, modulo N.
    // -----------------------------------------------------------------------
    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    req_rot;
    logic [N-1:0]    first_oh;
    logic [OW-1:0]   rot_idx;
    logic [OW:0]     pick_sum;
    logic [OW-1:0]   pick_idx;
    logic [N-1:0]    pick_oh;
    logic            any_req;

    assign req_dbl = {req, req};
    assign req_rot = N'(req_dbl >> ptr_q);
    assign any_req = |req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_first
            if (gi == 0) begin : g_lsb
                assign first_oh[gi] = req_rot[gi];
            end else begin : g_upper
                assign first_oh[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        rot_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (first_oh[k]) begin
                rot_idx = rot_idx | OW'(k);
            end
        end
    end

    assign pick_sum = {1'b0, ptr_q} + {1'b0, rot_idx};
    assign pick_idx = (pick_sum >= (OW+1)'(N)) ? OW'(pick_sum - (OW+1)'(N))
                                               : OW'(pick_sum);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_pick_oh
            assign pick_oh[gi] = (pick_idx == OW'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Conditions that end ownership.
    // -----------------------------------------------------------------------
    logic          rel_cond;
    logic          wd_hit;
    logic [OW-1:0] ptr_after_owner;

    // Release when the owner pulses rel or stops requesting.
    assign rel_cond = rel[owner_q] | ~req[owner_q];

    // The watchdog fires in the last permitted GRANT cycle.
    assign wd_hit   = (TIMEOUT > 0) && (timer_q == TLAST);

    // After a release, priority starts at the requester just above the
    // outgoing owner.
    assign ptr_after_owner = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;

    // -----------------------------------------------------------------------
    // FSM: next state and next registered outputs.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        owner_d = '0;
        busy_d  = 1'b0;
        sr_s_d  = 1'b0;
        sr_r_d  = 1'b0;
        tout_d  = 1'b0;
        ptr_d   = ptr_q;
        timer_d = timer_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick_oh;
                    owner_d = pick_idx;
                    busy_d  = 1'b1;
                    sr_s_d  = 1'b1;
                    timer_d = '0;
                end
            end

            ST_GRANT: begin
                if (rel_cond || wd_hit) begin
                    state_d = ST_RELEASE;
                    owner_d = owner_q;
                    busy_d  = 1'b1;
                    sr_r_d  = 1'b1;
                    // If a release and the watchdog expire together, treat it
                    // as a normal release.
                    tout_d  = wd_hit & ~rel_cond;
                    ptr_d   = ptr_after_owner;
                end else begin
                    gnt_d   = gnt_q;
                    owner_d = owner_q;
                    busy_d  = 1'b1;
                    // The timer stops at its last value and does not wrap.
                    if ((TIMEOUT > 0) && (timer_q != TLAST)) begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end

            ST_RELEASE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The lock flop should read 1 at the end of every GRANT cycle and 0 at the
    // end of every IDLE cycle. RELEASE is skipped because the flop is being
    // reset during that cycle.
    always_comb begin
        fault_d = fault_q;
        if ((state_q == ST_GRANT) && !sr_q) begin
            fault_d = 1'b1;
        end
        if ((state_q == ST_IDLE) && sr_q) begin
            fault_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // State registers.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            sr_s_q  <= 1'b0;
            sr_r_q  <= 1'b0;
            tout_q  <= 1'b0;
            fault_q <= 1'b0;
            ptr_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            sr_s_q  <= sr_s_d;
            sr_r_q  <= sr_r_d;
            tout_q  <= tout_d;
            fault_q <= fault_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
        end
    end

    // Run-time invariants: set and reset are never driven together, and at
    // most one requester holds a grant.
    always_ff @(posedge clk) begin
        if (!clear) begin
            assert (!(sr_s_q && sr_r_q));
            assert ($onehot0(gnt_q));
        end
    end

    assign gnt         = gnt_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign sr_s        = sr_s_q;
    assign sr_r        = sr_r_q;
    assign timeout_err = tout_q;
    assign fault       = fault_q;

endmodule
